cpu_run_controller: RTL and testbench

// Synthesizable run/halt controller between the top-level clock/reset and the processor core.

---
 rtl/cpu_run_controller.sv | 151 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/halt controller: sequences core reset, times the run, and latches the first halt cause.
// Halt states are absorbing; only the synchronous controller reset leaves them.
module cpu_run_controller #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned WDOG_CYCLES  = 64,
    parameter int unsigned NUM_TRAPS    = 1,
    parameter int unsigned CODE_W       = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_TRAPS-1:0] trap,
    input  logic                 retire,
    input  logic                 exit_valid,
    input  logic [CODE_W-1:0]    exit_code,
    output logic                 core_reset_n,
    output logic                 core_run,
    output logic                 done,
    output logic [2:0]           status,
    output logic [CODE_W-1:0]    result_code,
    output logic [3:0]           trap_idx,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    // A limit the saturating counter can never reach below all-ones disables the timeout.
    localparam bit TimeoutEn = (MAX_CYCLES != 0) &&
                               ((CNT_W >= 33) || (64'(MAX_CYCLES) < (64'd1 << CNT_W)));
    localparam bit WdogEn    = (WDOG_CYCLES != 0);

    localparam logic [2:0] StatRun      = 3'd0;
    localparam logic [2:0] StatPass     = 3'd1;
    localparam logic [2:0] StatFailExit = 3'd2;
    localparam logic [2:0] StatTrap     = 3'd3;
    localparam logic [2:0] StatTimeout  = 3'd4;
    localparam logic [2:0] StatHang     = 3'd5;

    typedef enum logic [2:0] {
        StHold,
        StRun,
        StHaltExit,
        StHaltTrap,
        StHaltTimeout,
        StHaltHang
    } state_e;

    state_e              state_q, state_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rstn_q, rstn_d;
    logic                done_q, done_d;
    logic [2:0]          status_q, status_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [3:0]          tidx_q, tidx_d;
    logic [3:0]          trap_low;
    logic                trap_found;

    always_comb begin
        trap_low   = 4'd0;
        trap_found = 1'b0;
        for (int i = 0; i < int'(NUM_TRAPS); i++) begin
            if (trap[i] && !trap_found) begin
                trap_low   = 4'(i);
                trap_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        wdog_d   = wdog_q;
        cnt_d    = cnt_q;
        rstn_d   = rstn_q;
        done_d   = done_q;
        status_d = status_q;
        code_d   = code_q;
        tidx_d   = tidx_q;

        unique case (state_q)
            StHold: begin
                hold_d = hold_q + HoldW'(1);
                if (hold_q == HoldW'(RESET_CYCLES - 1)) begin
                    state_d = StRun;
                    rstn_d  = 1'b1;
                end
            end
            StRun: begin
                cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                wdog_d = retire ? '0 : wdog_q + WdogW'(1);
                if (exit_valid) begin
                    state_d  = StHaltExit;
                    done_d   = 1'b1;
                    code_d   = exit_code;
                    status_d = (exit_code == '0) ? StatPass : StatFailExit;
                end else if (trap_found) begin
                    state_d  = StHaltTrap;
                    done_d   = 1'b1;
                    tidx_d   = trap_low;
                    status_d = StatTrap;
                end else if (TimeoutEn && (cnt_q == CNT_W'(MAX_CYCLES - 1))) begin
                    state_d  = StHaltTimeout;
                    done_d   = 1'b1;
                    status_d = StatTimeout;
                end else if (WdogEn && (wdog_q == WdogW'(WDOG_CYCLES - 1)) && !retire) begin
                    state_d  = StHaltHang;
                    done_d   = 1'b1;
                    status_d = StatHang;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StHold;
            hold_q   <= '0;
            wdog_q   <= '0;
            cnt_q    <= '0;
            rstn_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= StatRun;
            code_q   <= '0;
            tidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wdog_q   <= wdog_d;
            cnt_q    <= cnt_d;
            rstn_q   <= rstn_d;
            done_q   <= done_d;
            status_q <= status_d;
            code_q   <= code_d;
            tidx_q   <= tidx_d;
        end
    end

    assign core_reset_n = rstn_q;
    assign core_run     = (state_q == StRun);
    assign done         = done_q;
    assign status       = status_q;
    assign result_code  = code_q;
    assign trap_idx     = tidx_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: three instances share stimulus to cover
// timeout/watchdog limits, the disabled timeout and a narrow saturating counter.
module tb_cpu_run_controller;

    localparam int unsigned RstCycles = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] trap;
    logic       retire;
    logic       exit_valid;
    logic [7:0] exit_code;

    logic        core_reset_n, core_run, done;
    logic [2:0]  status;
    logic [7:0]  result_code;
    logic [3:0]  trap_idx;
    logic [31:0] cycle_count;

    logic        nto_core_reset_n, nto_core_run, nto_done;
    logic [2:0]  nto_status;
    logic [7:0]  nto_result_code;
    logic [3:0]  nto_trap_idx;
    logic [31:0] nto_cycle_count;

    logic        sat_core_reset_n, sat_core_run, sat_done;
    logic [2:0]  sat_status;
    logic [7:0]  sat_result_code;
    logic [3:0]  sat_trap_idx;
    logic [3:0]  sat_cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .RESET_CYCLES(RstCycles), .MAX_CYCLES(100), .WDOG_CYCLES(64),
        .NUM_TRAPS(4), .CODE_W(8), .CNT_W(32)
    ) u_dut (
        .clk(clk), .reset(reset), .trap(trap), .retire(retire),
        .exit_valid(exit_valid), .exit_code(exit_code),
        .core_reset_n(core_reset_n), .core_run(core_run), .done(done), .status(status),
        .result_code(result_code), .trap_idx(trap_idx), .cycle_count(cycle_count)
    );

    cpu_run_controller #(
        .RESET_CYCLES(RstCycles), .MAX_CYCLES(0), .WDOG_CYCLES(64),
        .NUM_TRAPS(4), .CODE_W(8), .CNT_W(32)
    ) u_dut_nto (
        .clk(clk), .reset(reset), .trap(trap), .retire(retire),
        .exit_valid(exit_valid), .exit_code(exit_code),
        .core_reset_n(nto_core_reset_n), .core_run(nto_core_run), .done(nto_done),
        .status(nto_status), .result_code(nto_result_code), .trap_idx(nto_trap_idx),
        .cycle_count(nto_cycle_count)
    );

    cpu_run_controller #(
        .RESET_CYCLES(1), .MAX_CYCLES(0), .WDOG_CYCLES(0),
        .NUM_TRAPS(4), .CODE_W(8), .CNT_W(4)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .trap(trap), .retire(retire),
        .exit_valid(exit_valid), .exit_code(exit_code),
        .core_reset_n(sat_core_reset_n), .core_run(sat_core_run), .done(sat_done),
        .status(sat_status), .result_code(sat_result_code), .trap_idx(sat_trap_idx),
        .cycle_count(sat_cycle_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        trap       = '0;
        exit_valid = 1'b0;
        exit_code  = '0;
        retire     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic enter_run();
        do_reset();
        repeat (RstCycles) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rstn"}, 32'(core_reset_n), 0);
        check_eq({tag, "_run"}, 32'(core_run), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_status"}, 32'(status), 0);
        check_eq({tag, "_code"}, 32'(result_code), 0);
        check_eq({tag, "_tidx"}, 32'(trap_idx), 0);
        check_eq({tag, "_cnt"}, cycle_count, 0);
    endtask

    initial begin
        reset = 1'b1;
        trap = '0; retire = 1'b0; exit_valid = 1'b0; exit_code = '0;

        // T1: reset state and HOLD sequencing
        do_reset();
        check_reset_outputs("t1_reset");
        tick();
        check_eq("t1_sat_rstn_after1", 32'(sat_core_reset_n), 1);
        check_eq("t1_rstn_after1", 32'(core_reset_n), 0);
        repeat (14) tick();
        check_eq("t1_rstn_after15", 32'(core_reset_n), 0);
        check_eq("t1_run_after15", 32'(core_run), 0);
        tick();
        check_eq("t1_rstn_after16", 32'(core_reset_n), 1);
        check_eq("t1_run_after16", 32'(core_run), 1);
        check_eq("t1_cnt_start", cycle_count, 0);
        tick();
        check_eq("t1_cnt_incr", cycle_count, 1);

        // T2: exit with zero code at RUN cycle 40, then frozen outputs
        enter_run();
        repeat (40) tick();
        check_eq("t2_pre_done", 32'(done), 0);
        check_eq("t2_pre_cnt", cycle_count, 40);
        exit_valid = 1'b1; exit_code = 8'h00;
        tick();
        exit_valid = 1'b0;
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_status", 32'(status), 1);
        check_eq("t2_cnt", cycle_count, 41);
        check_eq("t2_code", 32'(result_code), 0);
        check_eq("t2_run", 32'(core_run), 0);
        check_eq("t2_rstn", 32'(core_reset_n), 1);
        trap = 4'b0001; exit_valid = 1'b1; exit_code = 8'h55; retire = 1'b0;
        repeat (3) tick();
        check_eq("t2_frz_status", 32'(status), 1);
        check_eq("t2_frz_cnt", cycle_count, 41);
        check_eq("t2_frz_code", 32'(result_code), 0);
        check_eq("t2_frz_tidx", 32'(trap_idx), 0);

        // T2b: nonzero exit code
        enter_run();
        repeat (40) tick();
        exit_valid = 1'b1; exit_code = 8'h2A;
        tick();
        exit_valid = 1'b0;
        check_eq("t2b_status", 32'(status), 2);
        check_eq("t2b_code", 32'(result_code), 32'h2A);
        check_eq("t2b_cnt", cycle_count, 41);

        // T3: exit beats trap in the same cycle
        enter_run();
        repeat (5) tick();
        trap = 4'b1010; exit_valid = 1'b1; exit_code = 8'h07;
        tick();
        trap = '0; exit_valid = 1'b0;
        check_eq("t3_prio_status", 32'(status), 2);
        check_eq("t3_prio_tidx", 32'(trap_idx), 0);
        check_eq("t3_prio_code", 32'(result_code), 7);

        enter_run();
        repeat (5) tick();
        trap = 4'b1010;
        tick();
        trap = '0;
        check_eq("t3_trap_status", 32'(status), 3);
        check_eq("t3_trap_tidx", 32'(trap_idx), 1);
        check_eq("t3_trap_cnt", cycle_count, 6);
        check_eq("t3_trap_code", 32'(result_code), 0);

        enter_run();
        trap = 4'b1000;
        tick();
        trap = '0;
        check_eq("t3_trap3_tidx", 32'(trap_idx), 3);
        check_eq("t3_trap3_cnt", cycle_count, 1);

        // T4: timeout at MAX_CYCLES=100 with retire every cycle
        enter_run();
        repeat (99) tick();
        check_eq("t4_pre_done", 32'(done), 0);
        check_eq("t4_pre_cnt", cycle_count, 99);
        tick();
        check_eq("t4_done", 32'(done), 1);
        check_eq("t4_status", 32'(status), 4);
        check_eq("t4_cnt", cycle_count, 100);

        // T4b: disabled timeout runs on; narrow counter saturates
        enter_run();
        repeat (10000) tick();
        check_eq("t4b_nto_done", 32'(nto_done), 0);
        check_eq("t4b_nto_run", 32'(nto_core_run), 1);
        check_eq("t4b_nto_cnt", nto_cycle_count, 10000);
        check_eq("t4b_sat_done", 32'(sat_done), 0);
        check_eq("t4b_sat_cnt", 32'(sat_cycle_count), 15);

        // T5: retire for RUN cycles 0..9, then silence until watchdog
        enter_run();
        repeat (10) tick();
        retire = 1'b0;
        repeat (63) tick();
        check_eq("t5_pre_done", 32'(done), 0);
        check_eq("t5_pre_cnt", cycle_count, 73);
        tick();
        check_eq("t5_done", 32'(done), 1);
        check_eq("t5_status", 32'(status), 5);
        check_eq("t5_cnt", cycle_count, 74);

        // T5b: retire arrives on the last permitted idle cycle
        enter_run();
        repeat (10) tick();
        retire = 1'b0;
        repeat (63) tick();
        retire = 1'b1;
        tick();
        check_eq("t5b_done", 32'(done), 0);
        check_eq("t5b_cnt", cycle_count, 74);
        repeat (5) tick();
        check_eq("t5b_done_later", 32'(done), 0);
        check_eq("t5b_run", 32'(core_run), 1);

        // T6: reset mid-run and from a halt state
        enter_run();
        repeat (50) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("t6_midrun");
        reset = 1'b0;
        repeat (15) tick();
        check_eq("t6_hold_rstn", 32'(core_reset_n), 0);
        tick();
        check_eq("t6_rerun_rstn", 32'(core_reset_n), 1);
        check_eq("t6_rerun_cnt", cycle_count, 0);

        trap = 4'b0100;
        tick();
        trap = '0;
        check_eq("t6_trap_status", 32'(status), 3);
        check_eq("t6_trap_tidx", 32'(trap_idx), 2);
        reset = 1'b1;
        tick();
        check_reset_outputs("t6_halt");
        reset = 1'b0;
        repeat (RstCycles) tick();
        check_eq("t6_halt_rerun", 32'(core_run), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
